poly_mult_scheduler: RTL and testbench
======================================

Name: poly_mult_scheduler

Overview:
- Sequences one MULTIPLIER_WIDTH-wide polynomial multiplier so it computes the full product of two polynomials of length L = MULTIPLIER_WIDTH*NUM_TILES.
- Uses tiled schoolbook decomposition: issues every A-tile × B-tile pair to the multiplier, tags each issue, and accumulates the returned 2N-1 partial coefficients into a result buffer at the correct offset.
- Supports linear product or negacyclic reduction mod x^L+1, as used for HE ring arithmetic.
- Sits between the operand/result memory interface and the polynomial multiplier datapath.

Parameters:
- MULTIPLIER_WIDTH, 8, coefficients per tile (N); must match the multiplier instance.
- INPUT_WIDTH, 8, coefficient width W; all arithmetic is mod 2^W.
- NUM_TILES, 4, tiles per operand (T); L = N*T.
- MULT_LATENCY, 3, cycles from mult_start to mult_done; equals $clog2(MULTIPLIER_WIDTH) for the multiplier.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  start a full multiply; sampled in IDLE or DONE only
- negacyclic  in  1  mode, sampled on accepted go; 1 = reduce mod x^L+1
- op_we  in  1  operand tile write strobe; honoured only when busy=0
- op_sel  in  1  0 = A, 1 = B
- op_tile  in  clog2(T)  tile index for the write
- op_data  in  N*W  tile coefficients; element 0 = lowest degree
- rd_addr  in  clog2(2L)  result coefficient index
- rd_data  out  W  result coefficient (combinational from accumulator)
- busy  out  1  high in ISSUE/DRAIN
- done  out  1  high in DONE
- mult_start  out  1  to multiplier start
- mult_as  out  N*W  to multiplier as
- mult_bs  out  N*W  to multiplier bs
- mult_carry  out  (2N-1)*W  tied to 0
- mult_cs  in  (2N-1)*W  multiplier result
- mult_done  in  1  multiplier done

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - busy, done, mult_start = 0; mult_as, mult_bs = 0.
  - Operand registers, accumulator, counters and tag pipeline cleared.
  - Reset mid-operation aborts immediately; any later mult_done is ignored because state is IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE / DONE + go:
  - Clear the accumulator, latch negacyclic, reset i=j=0, clear the received count, go to ISSUE.
  - The accumulator clear and the first issue happen on the same edge.
- ISSUE, one pair per cycle:
  - mult_start=1, mult_as=A[i], mult_bs=B[j], registered.
  - Order: i outer, j inner, each 0..T-1.
  - Push tag s=i+j into a MULT_LATENCY-deep shift pipeline.
  - After pair (T-1,T-1), go to DRAIN; mult_start is high for exactly T^2 consecutive cycles.
- Accumulate on each mult_done while busy:
  - Pop the tag s. For each m in 0..2N-2, k = s*N+m.
  - Linear mode: acc[k] += cs[m].
  - Negacyclic mode, k<L: acc[k] += cs[m].
  - Negacyclic mode, k>=L: acc[k-L] -= cs[m].
  - Wrap mod 2^W; no saturation.
  - One accumulation per cycle; a write and a read of the same entry in one cycle resolve as read-old/write-new.
- DRAIN: when the received count reaches T^2 (including an accumulation in that cycle), go to DONE next edge.
- Latency:
  - done rises T^2 + MULT_LATENCY + 1 cycles after the accepted go edge.
  - done stays high until the next accepted go or reset.
- Ignored inputs:
  - go while busy is ignored.
  - op_we while busy is ignored; operand registers keep their contents across runs.
  - mult_done while not busy is ignored.
- Read side:
  - rd_data is valid in DONE.
  - Linear mode: indices 0..2L-2 are meaningful.
  - Negacyclic mode: indices 0..L-1 meaningful, L..2L-1 read 0.
  - rd_addr >= 2L-1 reads 0.
  - rd_data during busy is the partial sum, undefined for verification purposes.

Test Plan (N=4, T=2, W=8, MULT_LATENCY=2, L=8):
- Reset asserted with go=1, op_we=1 -> busy=done=mult_start=0, every rd_data=0; after release, no activity until go.
- Linear, A=[1,0,0,0,0,0,0,0], B=[1..8] -> mult_start high 4 cycles; done 7 cycles after go; rd_data[0..7]=1..8, [8..14]=0.
- Linear, A=B=all ones -> rd_data[k]=k+1 for k=0..7, 15-k for k=8..14 (1,2,..,8,7,..,1).
- Negacyclic, A=B=all ones -> rd_data[k]=(2k-6) mod 256: 250,252,254,0,2,4,6,8; rd_data[8..15]=0.
- Linear, A=B=all 255 -> identical to the all-ones linear result (wrap check); then a second go without reloading yields the same result.
- go and op_we pulsed during ISSUE -> both ignored, result unchanged; reset pulsed mid-ISSUE -> busy drops asynchronously, the following mult_done is ignored, acc reads 0.

Source files
------------

// File: rtl/poly_mult_scheduler.sv
// Tiled schoolbook scheduler: drives one N-coefficient polynomial multiplier over all
// A-tile x B-tile pairs and accumulates tagged partial products into a result buffer.
module poly_mult_scheduler #(
  parameter int unsigned MULTIPLIER_WIDTH = 8,
  parameter int unsigned INPUT_WIDTH      = 8,
  parameter int unsigned NUM_TILES        = 4,
  parameter int unsigned MULT_LATENCY     = 3,
  localparam int unsigned TileIdxW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int unsigned AddrW    = $clog2(2 * MULTIPLIER_WIDTH * NUM_TILES)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          go,
  input  logic                                          negacyclic,
  input  logic                                          op_we,
  input  logic                                          op_sel,
  input  logic [TileIdxW-1:0]                           op_tile,
  input  logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       op_data,
  input  logic [AddrW-1:0]                              rd_addr,
  output logic [INPUT_WIDTH-1:0]                        rd_data,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          mult_start,
  output logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       mult_as,
  output logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       mult_bs,
  output logic [(2*MULTIPLIER_WIDTH-1)*INPUT_WIDTH-1:0] mult_carry,
  input  logic [(2*MULTIPLIER_WIDTH-1)*INPUT_WIDTH-1:0] mult_cs,
  input  logic                                          mult_done
);

  localparam int unsigned N     = MULTIPLIER_WIDTH;
  localparam int unsigned W     = INPUT_WIDTH;
  localparam int unsigned T     = NUM_TILES;
  localparam int unsigned L     = N * T;
  localparam int unsigned Pairs = T * T;
  localparam int unsigned CntW  = $clog2(Pairs + 1);
  localparam int unsigned TagW  = $clog2(2 * T);
  localparam logic [TileIdxW-1:0] LastTile = TileIdxW'(T - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [N*W-1:0]      a_q [T];
  logic [N*W-1:0]      b_q [T];
  logic                neg_q, neg_d;
  logic [TileIdxW-1:0] i_q, i_d, j_q, j_d, issue_i, issue_j;
  logic [CntW-1:0]     rcv_q, rcv_d;
  logic                start_d, issue;
  logic [N*W-1:0]      as_d, bs_d;
  logic [TagW-1:0]     tag_q, tag_d;
  logic [TagW-1:0]     tag_pipe_q [MULT_LATENCY];
  logic [W-1:0]        acc_q [2*L];
  logic [W-1:0]        acc_d [2*L];
  logic [AddrW-1:0]    k;
  logic [W-1:0]        coef;
  logic                accept_go, accum;

  assign busy       = (state_q == StIssue) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign accept_go  = go && ((state_q == StIdle) || (state_q == StDone));
  assign accum      = mult_done && busy;
  assign mult_carry = '0;
  assign rd_data    = (rd_addr >= AddrW'(2 * L - 1)) ? '0 : acc_q[rd_addr];

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    i_d     = i_q;
    j_d     = j_q;
    rcv_d   = rcv_q;
    start_d = 1'b0;
    as_d    = mult_as;
    bs_d    = mult_bs;
    tag_d   = tag_q;
    issue   = 1'b0;
    issue_i = i_q;
    issue_j = j_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          neg_d   = negacyclic;
          rcv_d   = '0;
          issue   = 1'b1;
          issue_i = '0;
          issue_j = '0;
          state_d = StIssue;
        end
      end
      StIssue: issue = 1'b1;
      StDrain: if (rcv_q == CntW'(Pairs)) state_d = StDone;
      default: state_d = StIdle;
    endcase
    // Issue the current pair, then step j (inner) and i (outer).
    if (issue) begin
      start_d = 1'b1;
      as_d    = a_q[issue_i];
      bs_d    = b_q[issue_j];
      tag_d   = TagW'(issue_i) + TagW'(issue_j);
      if ((issue_i == LastTile) && (issue_j == LastTile)) begin
        state_d = StDrain;
      end else if (issue_j == LastTile) begin
        i_d = issue_i + 1'b1;
        j_d = '0;
      end else begin
        i_d = issue_i;
        j_d = issue_j + 1'b1;
      end
    end
    if (accum) rcv_d = rcv_q + 1'b1;
  end

  // Fold 2N-1 partial coefficients in at offset tag*N; negacyclic wraps the top half negated.
  always_comb begin
    acc_d = acc_q;
    k     = '0;
    coef  = '0;
    if (accept_go) begin
      acc_d = '{default: '0};
    end else if (accum) begin
      for (int m = 0; m < 2 * N - 1; m++) begin
        k    = AddrW'(tag_pipe_q[MULT_LATENCY-1]) * AddrW'(N) + AddrW'(m);
        coef = mult_cs[m*W +: W];
        if (!neg_q || (k < AddrW'(L))) begin
          acc_d[k] = acc_d[k] + coef;
        end else begin
          acc_d[k - AddrW'(L)] = acc_d[k - AddrW'(L)] - coef;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      neg_q      <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      rcv_q      <= '0;
      mult_start <= 1'b0;
      mult_as    <= '0;
      mult_bs    <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      neg_q      <= neg_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcv_q      <= rcv_d;
      mult_start <= start_d;
      mult_as    <= as_d;
      mult_bs    <= bs_d;
      tag_q      <= tag_d;
    end
  end

  // Tag of the pair driven on mult_as/bs follows the multiplier's latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < MULT_LATENCY; p++) tag_pipe_q[p] <= '0;
    end else begin
      tag_pipe_q[0] <= tag_q;
      for (int p = 1; p < MULT_LATENCY; p++) tag_pipe_q[p] <= tag_pipe_q[p-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < T; t++) begin
        a_q[t] <= '0;
        b_q[t] <= '0;
      end
      for (int e = 0; e < 2 * L; e++) acc_q[e] <= '0;
    end else begin
      if (op_we && !busy) begin
        if (op_sel) b_q[op_tile] <= op_data;
        else        a_q[op_tile] <= op_data;
      end
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_poly_mult_scheduler.sv
// Bench for poly_mult_scheduler: behavioural tile multiplier plus a whole-polynomial
// reference product, directed and random operands, latency and ignore/abort cases.
module tb_poly_mult_scheduler;

  localparam int N   = 4;
  localparam int T   = 2;
  localparam int W   = 8;
  localparam int LAT = 2;
  localparam int L   = N * T;
  localparam int TT  = T * T;
  localparam int TIW = (T > 1) ? $clog2(T) : 1;
  localparam int AW  = $clog2(2 * L);

  logic                   clk = 1'b0;
  logic                   reset, go, negacyclic, op_we, op_sel;
  logic [TIW-1:0]         op_tile;
  logic [N*W-1:0]         op_data;
  logic [AW-1:0]          rd_addr;
  logic [W-1:0]           rd_data;
  logic                   busy, done, mult_start, mult_done;
  logic [N*W-1:0]         mult_as, mult_bs;
  logic [(2*N-1)*W-1:0]   mult_carry, mult_cs;

  logic [LAT-1:0]         dv = '0;
  logic [(2*N-1)*W-1:0]   dcs [LAT];

  int a_v [L];
  int b_v [L];
  int ref_res [2*L];
  int errors = 0;
  int checks = 0;

  poly_mult_scheduler #(
    .MULTIPLIER_WIDTH(N),
    .INPUT_WIDTH     (W),
    .NUM_TILES       (T),
    .MULT_LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .negacyclic(negacyclic),
    .op_we     (op_we),
    .op_sel    (op_sel),
    .op_tile   (op_tile),
    .op_data   (op_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .mult_start(mult_start),
    .mult_as   (mult_as),
    .mult_bs   (mult_bs),
    .mult_carry(mult_carry),
    .mult_cs   (mult_cs),
    .mult_done (mult_done)
  );

  always #5 clk = ~clk;

  function automatic logic [(2*N-1)*W-1:0] mul_tile(input logic [N*W-1:0] x,
                                                     input logic [N*W-1:0] y);
    int s [2*N-1];
    logic [(2*N-1)*W-1:0] r;
    for (int m = 0; m < 2 * N - 1; m++) s[m] = 0;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        s[a+b] += int'(x[a*W +: W]) * int'(y[b*W +: W]);
    r = '0;
    for (int m = 0; m < 2 * N - 1; m++) r[m*W +: W] = W'(s[m]);
    return r;
  endfunction

  // Multiplier stand-in: done arrives LAT cycles after the cycle start is high; never reset.
  always @(posedge clk) begin
    dv[0]  <= mult_start;
    dcs[0] <= mul_tile(mult_as, mult_bs);
    for (int p = 1; p < LAT; p++) begin
      dv[p]  <= dv[p-1];
      dcs[p] <= dcs[p-1];
    end
  end
  assign mult_done = dv[LAT-1];
  assign mult_cs   = dcs[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compute_ref(input bit neg);
    for (int k = 0; k < 2 * L; k++) ref_res[k] = 0;
    for (int x = 0; x < L; x++)
      for (int y = 0; y < L; y++) begin
        if (!neg)          ref_res[x+y]   += a_v[x] * b_v[y];
        else if (x+y < L)  ref_res[x+y]   += a_v[x] * b_v[y];
        else               ref_res[x+y-L] -= a_v[x] * b_v[y];
      end
  endtask

  task automatic load_operands();
    for (int sel = 0; sel < 2; sel++)
      for (int t = 0; t < T; t++) begin
        @(negedge clk);
        op_we   = 1'b1;
        op_sel  = sel[0];
        op_tile = TIW'(t);
        for (int e = 0; e < N; e++)
          op_data[e*W +: W] = W'(sel == 1 ? b_v[t*N+e] : a_v[t*N+e]);
      end
    @(negedge clk);
    op_we = 1'b0;
  endtask

  task automatic check_result(input string tag);
    for (int k = 0; k < 2 * L; k++) begin
      rd_addr = AW'(k);
      #1;
      check($sformatf("%s[%0d]", tag, k), 32'(rd_data), 32'(ref_res[k] & 255));
    end
  endtask

  task automatic run(input bit neg, input bit disturb, input string tag);
    int starts;
    int cyc;
    @(negedge clk);
    negacyclic = neg;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = mult_start ? 1 : 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (disturb && cyc == 1) begin
        go      = 1'b1;
        op_we   = 1'b1;
        op_sel  = 1'($urandom);
        op_tile = TIW'($urandom);
        op_data = N*W'($urandom);
      end else begin
        go    = 1'b0;
        op_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (mult_start) starts++;
    end
    go    = 1'b0;
    op_we = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(TT + LAT + 1));
    check({tag, "_starts"}, 32'(starts), 32'(TT));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    compute_ref(neg);
    check_result(tag);
  endtask

  initial begin
    reset      = 1'b0;
    go         = 1'b1;
    op_we      = 1'b1;
    op_sel     = 1'b0;
    op_tile    = '0;
    op_data    = '1;
    negacyclic = 1'b0;
    rd_addr    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_start", 32'(mult_start), 32'd0);
    for (int k = 0; k < 2 * L; k++) begin
      rd_addr = AW'(k);
      #1;
      check($sformatf("rst_rd[%0d]", k), 32'(rd_data), 32'd0);
    end
    @(negedge clk);
    go    = 1'b0;
    op_we = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_start", 32'(mult_start), 32'd0);

    for (int x = 0; x < L; x++) begin a_v[x] = (x == 0) ? 1 : 0; b_v[x] = x + 1; end
    load_operands();
    run(1'b0, 1'b0, "impulse");

    for (int x = 0; x < L; x++) begin a_v[x] = 1; b_v[x] = 1; end
    load_operands();
    run(1'b0, 1'b0, "ones_lin");
    run(1'b1, 1'b0, "ones_neg");

    for (int x = 0; x < L; x++) begin a_v[x] = 255; b_v[x] = 255; end
    load_operands();
    run(1'b0, 1'b0, "ff_lin");
    run(1'b0, 1'b0, "ff_rerun");

    for (int it = 0; it < 4; it++) begin
      for (int x = 0; x < L; x++) begin
        a_v[x] = int'($urandom_range(0, 255));
        b_v[x] = int'($urandom_range(0, 255));
      end
      load_operands();
      run(1'($urandom), 1'b0, $sformatf("rand%0d", it));
    end

    run(1'b0, 1'b1, "disturb");

    for (int x = 0; x < L; x++) begin
      a_v[x] = int'($urandom_range(1, 255));
      b_v[x] = int'($urandom_range(1, 255));
    end
    load_operands();
    @(negedge clk);
    negacyclic = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_start", 32'(mult_start), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_done_after", 32'(done), 32'd0);
    for (int k = 0; k < 2 * L; k++) begin
      rd_addr = AW'(k);
      #1;
      check($sformatf("abort_rd[%0d]", k), 32'(rd_data), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
